// File: rtl/fir_stream_driver_if.sv
// Stream/coefficient bundle between upstream logic, the host and the FIR input port.
// The slave view belongs to fir_stream_driver; the master view belongs to whatever drives it.
interface fir_stream_driver_if #(
  parameter int DATA_W     = 8,
  parameter int NUM_COEFFS = 3
) ();

  logic signed [DATA_W-1:0]            in_data;
  logic                                in_valid;
  logic                                in_ready;
  logic        [NUM_COEFFS*DATA_W-1:0] coef_data;
  logic                                coef_req;
  logic                                coef_busy;
  logic signed [DATA_W-1:0]            x_n;
  logic                                s_axis_fir_tvalid;
  logic                                s_set_coeffs;
  logic                                overflow;

  modport slave (
    input  in_data, in_valid, coef_data, coef_req,
    output in_ready, coef_busy, x_n, s_axis_fir_tvalid, s_set_coeffs, overflow
  );

  modport master (
    output in_data, in_valid, coef_data, coef_req,
    input  in_ready, coef_busy, x_n, s_axis_fir_tvalid, s_set_coeffs, overflow
  );

endinterface

// File: rtl/fir_stream_driver.sv
// Source-side controller for the adaptive-coefficient FIR: buffers samples in a
// small FIFO and frames them onto x_n, inserting the coefficient-load sequence
// (coefficient 0 first) whenever the host requests it.
module fir_stream_driver #(
  parameter int DATA_W     = 8,
  parameter int NUM_COEFFS = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  fir_stream_driver_if.slave bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int K_W   = (NUM_COEFFS > 1) ? $clog2(NUM_COEFFS) : 1;
  localparam logic [K_W-1:0]   LAST_K    = K_W'(NUM_COEFFS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_STREAM = 1'b0,
    ST_LOAD   = 1'b1
  } state_e;

  state_e                          state_q, state_d;
  logic        [K_W-1:0]           k_q, k_d;
  logic        [NUM_COEFFS*DATA_W-1:0] shadow_q, shadow_d;
  logic                            busy_q, busy_d;
  logic                            overflow_q, overflow_d;
  logic signed [DATA_W-1:0]        x_n_q, x_n_d;
  logic                            tvalid_q, tvalid_d;
  logic                            set_q, set_d;

  logic signed [DATA_W-1:0]        mem_q [FIFO_DEPTH];
  logic        [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic        [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic        [CNT_W-1:0]         count_q, count_d;

  logic                            fifo_full;
  logic                            fifo_empty;
  logic                            push;
  logic                            pop;

  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == {CNT_W{1'b0}});
  // A full FIFO refuses input; the refused sample is dropped and flagged.
  assign push       = bus.in_valid && !fifo_full;

  assign bus.in_ready          = !fifo_full;
  assign bus.coef_busy         = busy_q;
  assign bus.overflow          = overflow_q;
  assign bus.x_n               = x_n_q;
  assign bus.s_axis_fir_tvalid = tvalid_q;
  assign bus.s_set_coeffs      = set_q;

  // Next-state and output decode for the STREAM/LOAD sequencer.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    shadow_d = shadow_q;
    x_n_d    = {DATA_W{1'b0}};
    tvalid_d = 1'b0;
    set_d    = 1'b0;
    pop      = 1'b0;
    case (state_q)
      ST_STREAM: begin
        // busy_q is still high for one STREAM cycle after a load; a request
        // arriving then is dropped rather than queued.
        if (bus.coef_req && !busy_q) begin
          shadow_d = bus.coef_data;
          k_d      = {K_W{1'b0}};
          state_d  = ST_LOAD;
        end else if (!fifo_empty) begin
          pop      = 1'b1;
          x_n_d    = mem_q[rd_ptr_q];
          tvalid_d = 1'b1;
        end else begin
          x_n_d    = {DATA_W{1'b0}};
          tvalid_d = 1'b0;
        end
      end
      ST_LOAD: begin
        x_n_d = shadow_q[int'(k_q)*DATA_W +: DATA_W];
        set_d = 1'b1;
        if (k_q == LAST_K) begin
          k_d     = {K_W{1'b0}};
          state_d = ST_STREAM;
        end else begin
          k_d     = k_q + K_W'(1);
        end
      end
      default: begin
        state_d = ST_STREAM;
        k_d     = {K_W{1'b0}};
      end
    endcase
    // Busy covers the request edge through the last strobe, so it falls
    // together with s_set_coeffs.
    busy_d     = (state_d == ST_LOAD) || (state_q == ST_LOAD);
    overflow_d = overflow_q || (bus.in_valid && fifo_full);
  end

  // FIFO pointer and occupancy next-state; pointers wrap at the power-of-two depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Sequencer, registered FIR-side outputs and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_STREAM;
      k_q        <= {K_W{1'b0}};
      shadow_q   <= {(NUM_COEFFS*DATA_W){1'b0}};
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      x_n_q      <= {DATA_W{1'b0}};
      tvalid_q   <= 1'b0;
      set_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      shadow_q   <= shadow_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
      x_n_q      <= x_n_d;
      tvalid_q   <= tvalid_d;
      set_q      <= set_d;
    end
  end

  // FIFO pointers and occupancy; reset flushes the buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

endmodule

// File: tb/tb_fir_stream_driver.sv
// Directed bench for fir_stream_driver: reset, impulse, coefficient load,
// load during stream, overflow (6-coefficient instance) and reset mid-load.
module tb_fir_stream_driver;

  logic clk;
  logic reset;

  int vectors;
  int miscompares;

  fir_stream_driver_if #(.DATA_W(8), .NUM_COEFFS(3)) bif ();
  fir_stream_driver_if #(.DATA_W(8), .NUM_COEFFS(6)) bif6 ();

  fir_stream_driver #(.DATA_W(8), .NUM_COEFFS(3), .FIFO_DEPTH(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  fir_stream_driver #(.DATA_W(8), .NUM_COEFFS(6), .FIFO_DEPTH(4)) u_dut6 (
    .clk   (clk),
    .reset (reset),
    .bus   (bif6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int imp[5];
    int ls_x[12];
    int ls_tv[12];
    int ls_set[12];
    int ov_x[11];

    vectors     = 0;
    miscompares = 0;
    imp    = '{0, 0, 1, 0, 0};
    ls_x   = '{0, 10, 11, 0, 1, 2, 3, 12, 13, 14, 15, 0};
    ls_tv  = '{0, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 0};
    ls_set = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0};
    ov_x   = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 50, 51, 52, 53, 0};

    bif.in_data   = 8'd0;
    bif.in_valid  = 1'b0;
    bif.coef_data = 24'd0;
    bif.coef_req  = 1'b0;
    bif6.in_data   = 8'd0;
    bif6.in_valid  = 1'b0;
    bif6.coef_data = 48'd0;
    bif6.coef_req  = 1'b0;

    // ---- reset values ----
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_x_n",      64'(bif.x_n),               64'd0);
    chk("rst_tvalid",   64'(bif.s_axis_fir_tvalid), 64'd0);
    chk("rst_set",      64'(bif.s_set_coeffs),      64'd0);
    chk("rst_busy",     64'(bif.coef_busy),         64'd0);
    chk("rst_overflow", 64'(bif.overflow),          64'd0);
    chk("rst_in_ready", 64'(bif.in_ready),          64'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_x_n",    64'(bif.x_n),               64'd0);
      chk("idle_tvalid", 64'(bif.s_axis_fir_tvalid), 64'd0);
    end

    // ---- impulse 0,0,1,0,0: each sample appears one edge after acceptance ----
    for (int i = 0; i < 5; i++) begin
      bif.in_data  = 8'(imp[i]);
      bif.in_valid = 1'b1;
      chk("imp_in_ready", 64'(bif.in_ready), 64'd1);
      tick();
      if (i > 0) begin
        chk("imp_x_n",    64'(bif.x_n),               64'(imp[i-1]));
        chk("imp_tvalid", 64'(bif.s_axis_fir_tvalid), 64'd1);
      end
    end
    bif.in_valid = 1'b0;
    tick();
    chk("imp_last_x_n",   64'(bif.x_n),               64'(imp[4]));
    chk("imp_last_tvalid", 64'(bif.s_axis_fir_tvalid), 64'd1);
    tick();
    chk("imp_drain_tvalid", 64'(bif.s_axis_fir_tvalid), 64'd0);

    // ---- coefficient load {3,2,1}, FIFO empty ----
    bif.coef_data = {8'd3, 8'd2, 8'd1};
    bif.coef_req  = 1'b1;
    tick();
    bif.coef_req  = 1'b0;
    chk("cl_req_busy",   64'(bif.coef_busy),         64'd1);
    chk("cl_req_set",    64'(bif.s_set_coeffs),      64'd0);
    chk("cl_req_tvalid", 64'(bif.s_axis_fir_tvalid), 64'd0);
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("cl_set",    64'(bif.s_set_coeffs),      64'd1);
      chk("cl_x_n",    64'(bif.x_n),               64'(j + 1));
      chk("cl_tvalid", 64'(bif.s_axis_fir_tvalid), 64'd0);
      chk("cl_busy",   64'(bif.coef_busy),         64'd1);
    end
    tick();
    chk("cl_end_set",  64'(bif.s_set_coeffs), 64'd0);
    chk("cl_end_busy", 64'(bif.coef_busy),    64'd0);

    // ---- load during stream: push 10..15, request while 12 is at the head ----
    for (int c = 0; c < 12; c++) begin
      bif.in_valid = (c < 6) ? 1'b1 : 1'b0;
      bif.in_data  = 8'(10 + c);
      bif.coef_req = (c == 3) ? 1'b1 : 1'b0;
      if (c < 6) begin
        chk("ls_in_ready", 64'(bif.in_ready), 64'd1);
      end
      tick();
      chk("ls_tvalid",   64'(bif.s_axis_fir_tvalid), 64'(ls_tv[c]));
      chk("ls_set",      64'(bif.s_set_coeffs),      64'(ls_set[c]));
      chk("ls_x_n",      64'(bif.x_n),               64'(ls_x[c]));
      chk("ls_overflow", 64'(bif.overflow),          64'd0);
    end
    bif.in_valid = 1'b0;
    bif.coef_req = 1'b0;

    // ---- overflow on the 6-coefficient instance while it is loading ----
    bif6.coef_data = {8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21};
    bif6.coef_req  = 1'b1;
    tick();
    bif6.coef_req  = 1'b0;
    chk("ov_req_busy", 64'(bif6.coef_busy), 64'd1);
    for (int c = 0; c < 11; c++) begin
      bif6.in_valid = (c < 6) ? 1'b1 : 1'b0;
      bif6.in_data  = 8'(50 + c);
      if (c < 6) begin
        chk("ov_in_ready", 64'(bif6.in_ready), (c < 4) ? 64'd1 : 64'd0);
      end
      tick();
      chk("ov_set",    64'(bif6.s_set_coeffs),      (c < 6) ? 64'd1 : 64'd0);
      chk("ov_tvalid", 64'(bif6.s_axis_fir_tvalid), (c >= 6 && c < 10) ? 64'd1 : 64'd0);
      chk("ov_x_n",    64'(bif6.x_n),               64'(ov_x[c]));
      chk("ov_flag",   64'(bif6.overflow),          (c >= 4) ? 64'd1 : 64'd0);
    end
    bif6.in_valid = 1'b0;
    chk("ov_busy_end", 64'(bif6.coef_busy), 64'd0);

    // ---- reset mid-load, then a complete fresh load ----
    bif.coef_data = {8'd3, 8'd2, 8'd1};
    bif.coef_req  = 1'b1;
    tick();
    bif.coef_req  = 1'b0;
    bif.in_valid  = 1'b1;
    bif.in_data   = 8'd77;
    tick();
    chk("rml_first_set", 64'(bif.s_set_coeffs), 64'd1);
    chk("rml_first_x_n", 64'(bif.x_n),          64'd1);
    bif.in_valid = 1'b0;
    reset        = 1'b1;
    tick();
    reset        = 1'b0;
    chk("rml_set",       64'(bif.s_set_coeffs),      64'd0);
    chk("rml_busy",      64'(bif.coef_busy),         64'd0);
    chk("rml_x_n",       64'(bif.x_n),               64'd0);
    chk("rml_tvalid",    64'(bif.s_axis_fir_tvalid), 64'd0);
    chk("rml_in_ready",  64'(bif.in_ready),          64'd1);
    chk("rml_ovf6_clr",  64'(bif6.overflow),         64'd0);
    tick();
    chk("rml_flushed_tvalid", 64'(bif.s_axis_fir_tvalid), 64'd0);
    chk("rml_flushed_set",    64'(bif.s_set_coeffs),      64'd0);
    bif.coef_req = 1'b1;
    tick();
    bif.coef_req = 1'b0;
    chk("rml2_req_busy", 64'(bif.coef_busy), 64'd1);
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("rml2_set",  64'(bif.s_set_coeffs), 64'd1);
      chk("rml2_x_n",  64'(bif.x_n),          64'(j + 1));
      chk("rml2_busy", 64'(bif.coef_busy),    64'd1);
    end
    tick();
    chk("rml2_end_set",    64'(bif.s_set_coeffs),      64'd0);
    chk("rml2_end_busy",   64'(bif.coef_busy),         64'd0);
    chk("rml2_end_tvalid", 64'(bif.s_axis_fir_tvalid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fir_stream_driver.md
# fir_stream_driver

Source-side controller for the adaptive-coefficient FIR. It accepts a sample stream from upstream logic and coefficient-update requests from a host. It drives the FIR input port (`x_n`, `s_axis_fir_tvalid`, `s_set_coeffs`) with a correctly framed stream, including the multi-cycle coefficient-load sequence. A small FIFO buffers samples so that none are lost while a coefficient load holds the stream off.

## Interface
- `DATA_W`, 8: sample and coefficient width (signed two's complement).
- `NUM_COEFFS`, 3: number of unique symmetric coefficients sent per load.
- `FIFO_DEPTH`, 4: sample buffer depth; power of two, ≥ `NUM_COEFFS`+1.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_data`  in  `DATA_W`  upstream sample, signed.
- `in_valid`  in  1  upstream sample valid.
- `in_ready`  out  1  FIFO not full; a sample is accepted on an edge where `in_valid && in_ready`.
- `coef_data`  in  `NUM_COEFFS*DATA_W`  new coefficients; coefficient k occupies bits [k*DATA_W +: DATA_W].
- `coef_req`  in  1  single-cycle request to load `coef_data`.
- `coef_busy`  out  1  high while a load is pending or in progress.
- `x_n`  out  `DATA_W`  data to the FIR; registered.
- `s_axis_fir_tvalid`  out  1  sample valid to the FIR; registered.
- `s_set_coeffs`  out  1  coefficient-load strobe to the FIR; registered.
- `overflow`  out  1  sticky flag; set when `in_valid && !in_ready`.

## Operation
- Reset values (synchronous, active-high):
  - `x_n`=0, `s_axis_fir_tvalid`=0, `s_set_coeffs`=0.
  - `coef_busy`=0, `overflow`=0.
  - FIFO emptied, so `in_ready`=1 on the first cycle after reset.
  - FSM enters STREAM.
- FSM states: STREAM and LOAD.
- STREAM:
  - If `coef_req`=1: latch `coef_data` into a shadow register, set k=0 and go to LOAD. No sample is popped on this edge.
  - Else if the FIFO is non-empty: pop the head. Next cycle `x_n`=head, `s_axis_fir_tvalid`=1, `s_set_coeffs`=0.
  - Else (FIFO empty): next cycle `x_n`=0, `s_axis_fir_tvalid`=0, `s_set_coeffs`=0.
- LOAD:
  - Each cycle: `s_set_coeffs`=1, `s_axis_fir_tvalid`=0, `x_n`=shadow[k], then k increments.
  - Coefficient 0 (lowest slice of `coef_data`) is sent first.
  - After coefficient `NUM_COEFFS`-1 is sent, return to STREAM. The next output cycle is normal stream data or a bubble.
  - `s_set_coeffs` and `s_axis_fir_tvalid` are never both 1.
- `coef_busy`:
  - Goes high on the edge that latches `coef_req`.
  - Stays high through the last LOAD cycle.
  - Drops on the same edge on which `s_set_coeffs` deasserts.
- `coef_req` while `coef_busy`=1 is ignored and not queued; the host must wait for `coef_busy`=0.
- The FIFO keeps accepting input during LOAD. `in_ready` = !full, driven combinationally from the occupancy count.
- Simultaneous push and pop when full is not allowed, because `in_ready`=0. Simultaneous push and pop when non-full keeps the count unchanged.
- `overflow` stays set until reset. The offered sample is dropped and FIFO contents are unaffected.
- Reset during LOAD:
  - Aborts the sequence; the partial coefficient set is abandoned.
  - All outputs take their reset values on that edge and the FIFO is flushed.
  - The FIR's own reset restores its default coefficients.
- FIFO pointers wrap modulo `FIFO_DEPTH`. Occupancy uses a count register of width log2(`FIFO_DEPTH`)+1.

## Timing
- Sample latency: a sample accepted on edge n into an empty FIFO, with the FSM in STREAM and no `coef_req`, is presented on `x_n`/`s_axis_fir_tvalid` after edge n+1.
- Throughput: one sample per cycle sustained in STREAM.
- Load: `coef_req` seen on edge n gives `s_set_coeffs`=1 after edges n+1 … n+`NUM_COEFFS`. Stream output resumes after edge n+`NUM_COEFFS`+1.
- The stall caused by a load is exactly `NUM_COEFFS`+1 output cycles, counting the request edge.
- A sample that is in flight when `coef_req` arrives stays at the FIFO head and is sent first after LOAD.

## Test plan
- **Reset values:** assert `reset` for 1 cycle, hold `in_valid`=0 → all outputs 0, `in_ready`=1; `x_n`=0 and `s_axis_fir_tvalid`=0 for 10 cycles.
- **Impulse:** push 0,0,1,0,0 on consecutive cycles → `x_n` shows 0,0,1,0,0 with `s_axis_fir_tvalid`=1, each one cycle after acceptance.
- **Coefficient load:** pulse `coef_req` with `coef_data`={3,2,1} (slice0=1), FIFO empty → `s_set_coeffs`=1 for 3 cycles with `x_n`=1,2,3 and `s_axis_fir_tvalid`=0; `coef_busy` high for exactly those 3 cycles plus the request edge.
- **Load during stream:** push 10..15 continuously and assert `coef_req` while 12 is at the FIFO head → output order 10,11,[1,2,3 load],12,13,14,15 with no loss; `in_ready` never drops and `overflow`=0.
- **Overflow:** with the FSM in LOAD (`NUM_COEFFS` raised to 6 via parameter), push 6 samples → `in_ready`=0 after 4; the 5th push sets `overflow`=1; output later shows the first 4 samples only.
- **Reset mid-load:** assert `reset` on the 2nd LOAD cycle → next cycle `s_set_coeffs`=0, `coef_busy`=0, FIFO empty; a new `coef_req` afterwards performs a full 3-cycle load.
